// File: rtl/motor_pkg.sv
// Shared definitions for the six-step commutation scheduler:
// FSM state encoding, step width, step-to-gate table and step sequencing helpers.
package motor_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } schedStateT;

    // Entry = {hi[2:0], lo[2:0]}, bit order {C,B,A}; step n drives hi/lo: A/B, A/C, B/C, B/A, C/A, C/B
    localparam logic [5:0] STEP_TABLE [0:5] = '{
        6'b001_010,
        6'b001_100,
        6'b010_100,
        6'b010_001,
        6'b100_001,
        6'b100_010
    };

    function automatic logic [5:0] stepGates(input logic [STEP_W-1:0] s);
        logic [5:0] g;
        g = '0;
        if (s < 3'd6) g = STEP_TABLE[s];
        return g;
    endfunction

    function automatic logic [STEP_W-1:0] nextStep(input logic [STEP_W-1:0] s, input logic fwd);
        if (fwd) return (s == 3'd5) ? 3'd0 : s + 3'd1;
        else     return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/commutation_scheduler_6step_if.sv
// Control/status bundle between the motor control logic (master) and the
// commutation scheduler (slave).
interface commutation_scheduler_6step_if
    import motor_pkg::*;
#(
    parameter int PERIOD_W = 16
);
    logic                startI;
    logic                stopI;
    logic                dirI;
    logic [PERIOD_W-1:0] periodI;
    logic                cfgLoadI;
    logic                busyO;
    logic [STEP_W-1:0]   stepO;
    logic                stepPulseO;
    logic [2:0]          phaseHiO;
    logic [2:0]          phaseLoO;

    modport master (
        output startI, stopI, dirI, periodI, cfgLoadI,
        input  busyO, stepO, stepPulseO, phaseHiO, phaseLoO
    );

    modport slave (
        input  startI, stopI, dirI, periodI, cfgLoadI,
        output busyO, stepO, stepPulseO, phaseHiO, phaseLoO
    );
endinterface

// File: rtl/commutation_scheduler_6step_tick_down_counter.sv
// Loadable down-counter advanced by the 1 MHz tick enable; saturates at zero
// and flags it. Load has priority over a coincident tick.
module tick_down_counter #(
    parameter int W = 16
) (
    input  logic         clkI,
    input  logic         rstI,
    input  logic         loadI,
    input  logic [W-1:0] loadValI,
    input  logic         tickI,
    output logic         zeroO
);
    logic [W-1:0] countQ;

    always_ff @(posedge clkI) begin
        if (rstI)                          countQ <= '0;
        else if (loadI)                    countQ <= loadValI;
        else if (tickI && countQ != '0)    countQ <= countQ - 1'b1;
    end

    assign zeroO = (countQ == '0);
endmodule

// File: rtl/commutation_scheduler_6step.sv
// Six-step trapezoidal commutation scheduler with programmable step period.
// Define DEADTIME_EN to insert DEAD_TICKS of all-gates-off between steps.
module commutation_scheduler_6step
    import motor_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 4,
    parameter int DEAD_TICKS = 2
) (
    input logic clk50mhzI,
    input logic rstI,
    input logic tick1mhzI,
    commutation_scheduler_6step_if.slave ctl
);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    schedStateT          stateQ, stateD;
    logic [STEP_W-1:0]   stepQ, stepD;
    logic                busyQ, busyD;
    logic                pulseQ, pulseD;
    logic [2:0]          hiQ, hiD, loQ, loD;
    logic [PERIOD_W-1:0] shadowQ;
    logic                perLoad, perZero;

    always_ff @(posedge clk50mhzI) begin
        if (rstI)              shadowQ <= MIN_P;
        else if (ctl.cfgLoadI) shadowQ <= (ctl.periodI < MIN_P) ? MIN_P : ctl.periodI;
    end

    // Loaded with period-1 so the tick seen at zero is the step boundary
    tick_down_counter #(.W(PERIOD_W)) uPeriodCnt (
        .clkI     (clk50mhzI),
        .rstI     (rstI),
        .loadI    (perLoad),
        .loadValI (shadowQ - 1'b1),
        .tickI    (tick1mhzI),
        .zeroO    (perZero)
    );

`ifdef DEADTIME_EN
    localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    logic              deadLoad, deadZero;
    logic [STEP_W-1:0] pendQ, pendD;

    tick_down_counter #(.W(DEAD_W)) uDeadCnt (
        .clkI     (clk50mhzI),
        .rstI     (rstI),
        .loadI    (deadLoad),
        .loadValI (DEAD_W'(DEAD_TICKS - 1)),
        .tickI    (tick1mhzI),
        .zeroO    (deadZero)
    );

    always_ff @(posedge clk50mhzI) begin
        if (rstI) pendQ <= '0;
        else      pendQ <= pendD;
    end
`endif

    always_ff @(posedge clk50mhzI) begin
        if (rstI) begin
            stateQ <= IDLE;
            stepQ  <= '0;
            busyQ  <= 1'b0;
            pulseQ <= 1'b0;
            hiQ    <= '0;
            loQ    <= '0;
        end else begin
            stateQ <= stateD;
            stepQ  <= stepD;
            busyQ  <= busyD;
            pulseQ <= pulseD;
            hiQ    <= hiD;
            loQ    <= loD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        stepD   = stepQ;
        pulseD  = 1'b0;
        perLoad = 1'b0;
`ifdef DEADTIME_EN
        deadLoad = 1'b0;
        pendD    = pendQ;
`endif
        if (ctl.stopI) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (ctl.startI) begin
                        stateD  = RUN;
                        stepD   = '0;
                        pulseD  = 1'b1;
                        perLoad = 1'b1;
                    end
                end
                RUN: begin
                    if (tick1mhzI && perZero) begin
`ifdef DEADTIME_EN
                        stateD   = DEAD;
                        pendD    = nextStep(stepQ, ctl.dirI);
                        deadLoad = 1'b1;
`else
                        stepD   = nextStep(stepQ, ctl.dirI);
                        pulseD  = 1'b1;
                        perLoad = 1'b1;
`endif
                    end
                end
`ifdef DEADTIME_EN
                DEAD: begin
                    if (tick1mhzI && deadZero) begin
                        stateD  = RUN;
                        stepD   = pendQ;
                        pulseD  = 1'b1;
                        perLoad = 1'b1;
                    end
                end
`endif
                default: stateD = IDLE;
            endcase
        end
        busyD      = (stateD != IDLE);
        {hiD, loD} = (stateD == RUN) ? stepGates(stepD) : 6'b0;
    end

    assign ctl.busyO      = busyQ;
    assign ctl.stepO      = stepQ;
    assign ctl.stepPulseO = pulseQ;
    assign ctl.phaseHiO   = hiQ;
    assign ctl.phaseLoO   = loQ;
endmodule

// File: tb/tb_commutation_scheduler_6step.sv
// Self-checking bench for commutation_scheduler_6step: directed vector table,
// multi-cycle step-timing sequences and randomized traffic against a reference model.
module tb_commutation_scheduler_6step;
    localparam int PW   = 16;
    localparam int MINP = 4;
    localparam int DTK  = 2;
`ifdef DEADTIME_EN
    localparam int DT = DTK;
`else
    localparam int DT = 0;
`endif
    localparam int HI_IDX [6] = '{0, 0, 1, 1, 2, 2};
    localparam int LO_IDX [6] = '{1, 2, 2, 0, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;

    commutation_scheduler_6step_if #(.PERIOD_W(PW)) bus ();

    commutation_scheduler_6step #(
        .PERIOD_W   (PW),
        .MIN_PERIOD (MINP),
        .DEAD_TICKS (DTK)
    ) dut (
        .clk50mhzI (clk),
        .rstI      (rst),
        .tick1mhzI (tick),
        .ctl       (bus.slave)
    );

    initial forever #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int overlaps = 0;
    int printed = 0;

    // Reference model: 0 idle, 1 run, 2 dead; elapsed ticks counted upward per step
    int mMode = 0, mStep = 0, mDur = 0, mEl = 0, mDeadEl = 0, mPend = 0, mShadow = MINP;
    bit mPulse = 0;

    int obsStep [8];
    int obsDur  [8];

    always @(negedge clk) if ((bus.phaseHiO & bus.phaseLoO) != 3'b000) overlaps++;

    task automatic report(string nm, string act, string exp);
        failures++;
        if (printed < 40) begin
            printed++;
            $display("FAIL %s t=%0t actual=%s expected=%s", nm, $time, act, exp);
        end
    endtask

    task automatic chk(string nm, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) report(nm, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chkInt(string nm, int act, int exp);
        checks++;
        if (act != exp) report(nm, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    function automatic logic [10:0] actVec();
        return {bus.busyO, bus.stepO, bus.stepPulseO, bus.phaseHiO, bus.phaseLoO};
    endfunction

    function automatic logic [10:0] expVec();
        logic [2:0] h, l;
        h = 3'b000;
        l = 3'b000;
        if (mMode == 1) begin
            h = 3'(1 << HI_IDX[mStep]);
            l = 3'(1 << LO_IDX[mStep]);
        end
        return {(mMode != 0), 3'(mStep), mPulse, h, l};
    endfunction

    task automatic modelEdge(input bit r, st, sp, tk, dr, cf, input int per);
        int nxt;
        mPulse = 0;
        if (r) begin
            mMode = 0; mStep = 0; mShadow = MINP;
            return;
        end
        if (sp) begin
            mMode = 0;
        end else if (mMode == 0) begin
            if (st) begin
                mMode = 1; mStep = 0; mDur = mShadow; mEl = 0; mPulse = 1;
            end
        end else if (mMode == 1) begin
            if (tk) begin
                mEl++;
                if (mEl == mDur) begin
                    nxt = dr ? (mStep + 1) % 6 : (mStep + 5) % 6;
`ifdef DEADTIME_EN
                    mMode = 2; mDeadEl = 0; mPend = nxt;
`else
                    mStep = nxt; mDur = mShadow; mEl = 0; mPulse = 1;
`endif
                end
            end
        end else if (tk) begin
            mDeadEl++;
            if (mDeadEl == DTK) begin
                mMode = 1; mStep = mPend; mDur = mShadow; mEl = 0; mPulse = 1;
            end
        end
        if (cf) mShadow = (per < MINP) ? MINP : per;
    endtask

    task automatic cycle();
        bit r, st, sp, tk, dr, cf;
        int per;
        r = rst; st = bus.startI; sp = bus.stopI; tk = tick;
        dr = bus.dirI; cf = bus.cfgLoadI; per = int'(bus.periodI);
        @(posedge clk);
        #1;
        bus.startI = 1'b0; bus.stopI = 1'b0; bus.cfgLoadI = 1'b0; tick = 1'b0;
        modelEdge(r, st, sp, tk, dr, cf, per);
        chk("model", actVec(), expVec());
    endtask

    task automatic observe(int n);
        int k, tc, it;
        bit applied;
        k = 0; tc = 0; it = 0;
        while (k < n && it < 3000) begin
            tick = (it % 2 == 0);
            applied = tick;
            cycle();
            it++;
            if (applied) tc++;
            if (bus.stepPulseO) begin
                obsStep[k] = int'(bus.stepO);
                obsDur[k]  = tc;
                tc = 0;
                k++;
            end
        end
        chkInt("observe_pulses", k, n);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cycle();
            cycle();
        end
    endtask

    typedef struct {
        logic        st, sp, tk, dr, cf;
        logic [15:0] per;
        logic [10:0] exp;
    } vecT;

    localparam logic [10:0] V_IDLE = 11'b0_000_0_000_000;
    localparam logic [10:0] V_RUNP = 11'b1_000_1_001_010;
    localparam logic [10:0] V_RUN0 = 11'b1_000_0_001_010;

    vecT vt [12];

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, V_IDLE};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, V_RUNP};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, V_RUN0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, V_RUN0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, V_RUN0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, V_RUN0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, V_IDLE};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, V_IDLE};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, V_IDLE};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, V_RUNP};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6, V_RUN0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, V_IDLE};

        bus.startI = 1'b0; bus.stopI = 1'b0; bus.dirI = 1'b1;
        bus.periodI = '0; bus.cfgLoadI = 1'b0;

        // Reset and idle ticks
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("reset", actVec(), V_IDLE);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            cycle();
            chk("idle_tick", actVec(), V_IDLE);
        end

        for (int i = 0; i < 12; i++) begin
            bus.startI = vt[i].st; bus.stopI = vt[i].sp; tick = vt[i].tk;
            bus.dirI = vt[i].dr; bus.cfgLoadI = vt[i].cf; bus.periodI = vt[i].per;
            cycle();
            chk($sformatf("vec%0d", i), actVec(), vt[i].exp);
        end

        // Forward run, period 5
        bus.periodI = 16'd5; bus.cfgLoadI = 1'b1; cycle();
        bus.dirI = 1'b1; bus.startI = 1'b1; cycle();
        chkInt("fwd_start_step", int'(bus.stepO), 0);
        chkInt("fwd_start_pulse", int'(bus.stepPulseO), 1);
        observe(6);
        for (int i = 0; i < 6; i++) begin
            chkInt($sformatf("fwd_step%0d", i), obsStep[i], (i + 1) % 6);
            chkInt($sformatf("fwd_dur%0d", i), obsDur[i], 5 + DT);
        end
        bus.stopI = 1'b1; cycle();

        // Reverse run
        bus.dirI = 1'b0; bus.startI = 1'b1; cycle();
        observe(2);
        chkInt("rev_step0", obsStep[0], 5);
        chkInt("rev_step1", obsStep[1], 4);
        chkInt("rev_dur", obsDur[1], 5 + DT);
        bus.stopI = 1'b1; cycle();

        // Clamp to minimum, then mid-step reload
        bus.periodI = 16'd2; bus.cfgLoadI = 1'b1; cycle();
        bus.startI = 1'b1; cycle();
        ticks(2);
        bus.periodI = 16'd10; bus.cfgLoadI = 1'b1; cycle();
        observe(2);
        chkInt("clamp_dur", obsDur[0] + 2, MINP + DT);
        chkInt("reload_dur", obsDur[1], 10 + DT);
        bus.stopI = 1'b1; cycle();

        // Stop mid-step
        bus.startI = 1'b1; cycle();
        ticks(2);
        bus.stopI = 1'b1; cycle();
        chkInt("stop_busy", int'(bus.busyO), 0);
        chkInt("stop_gates", int'({bus.phaseHiO, bus.phaseLoO}), 0);

        // Start while running is ignored
        bus.startI = 1'b1; cycle();
        ticks(2);
        bus.startI = 1'b1; cycle();
        chkInt("restart_pulse", int'(bus.stepPulseO), 0);
        chkInt("restart_step", int'(bus.stepO), 0);
        observe(1);
        chkInt("restart_dur", obsDur[0] + 2, 10 + DT);
        bus.stopI = 1'b1; cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 499) == 0);
            tick         = ($urandom_range(0, 2) == 0);
            bus.startI   = ($urandom_range(0, 29) == 0);
            bus.stopI    = ($urandom_range(0, 119) == 0);
            bus.dirI     = $urandom_range(0, 1) == 1;
            bus.cfgLoadI = ($urandom_range(0, 49) == 0);
            bus.periodI  = PW'($urandom_range(0, 12));
            cycle();
        end
        rst = 1'b0;

        chkInt("no_overlap", overlaps, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
